// File: rtl/fb_pkg.sv
// Shared types and helpers for the N-way framebuffer.
// FB_CLEAR_ON_SWAP_EN adds the WR_CLEAR write state (blank each new write buffer).
package fb_pkg;

   localparam int FB_DEFAULT_DEPTH = 76800;

   typedef enum logic [1:0] {
      BUF_FREE,
      BUF_WRITE,
      BUF_PENDING,
      BUF_DISPLAY
   } buf_state_e;

`ifdef FB_CLEAR_ON_SWAP_EN
   typedef enum logic [1:0] {
      WR_ACTIVE,
      WR_STALL,
      WR_CLEAR
   } wr_state_e;
   // State entered whenever a buffer is newly handed to the writer
   localparam wr_state_e WR_ENTRY = WR_CLEAR;
`else
   typedef enum logic [1:0] {
      WR_ACTIVE,
      WR_STALL
   } wr_state_e;
   localparam wr_state_e WR_ENTRY = WR_ACTIVE;
`endif

   function automatic int buf_idx_w(input int num_bufs);
      return (num_bufs <= 2) ? 1 : $clog2(num_bufs);
   endfunction

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: simple dual-port inferred RAM, one write port,
// one read port with a single cycle of read latency.
module fb_bank #(
   parameter int DEPTH       = 76800,
   parameter int PIXEL_WIDTH = 8,
   localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic                   clk,
   input  logic                   we,
   input  logic [IDX_W-1:0]       wr_addr,
   input  logic [PIXEL_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]       rd_addr,
   output logic [PIXEL_WIDTH-1:0] rd_data
);

   logic [PIXEL_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/multi_framebuffer.sv
// N-way framebuffer between a GPU rasteriser and VGA scanout with pending-frame
// queueing, back-pressure and latest-frame-wins dropping.
// Optional: FB_CLEAR_ON_SWAP_EN clears every newly assigned write buffer to clear_color.
module multi_framebuffer
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 17,
   parameter int DEPTH       = FB_DEFAULT_DEPTH,
   parameter int PIXEL_WIDTH = 8,
   parameter int NUM_BUFS    = 3,
   localparam int BW         = buf_idx_w(NUM_BUFS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   vsync,
`ifdef FB_CLEAR_ON_SWAP_EN
   input  logic [PIXEL_WIDTH-1:0] clear_color,
`endif
   input  logic                   wea,
   input  logic [ADDR_WIDTH-1:0]  addra,
   input  logic [PIXEL_WIDTH-1:0] dina,
   input  logic                   frame_done,
   output logic                   wr_ready,
   input  logic [ADDR_WIDTH-1:0]  addrb,
   output logic [PIXEL_WIDTH-1:0] doutb,
   output logic [BW-1:0]          disp_idx,
   output logic [BW-1:0]          wr_idx,
   output logic                   swap_pulse,
   output logic                   frame_drop
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   logic vs_s1, vs_s2, vs_prev, vs_fall;

   buf_state_e buf_state [NUM_BUFS];
   buf_state_e n_state   [NUM_BUFS];
   wr_state_e  wr_state, n_wst;
   logic [BW-1:0] pend_idx, n_pend, n_disp, n_wr, free_idx;
   logic pend_valid, n_pv, do_swap, do_drop, need_buf, found;

   logic [PIXEL_WIDTH-1:0] bank_q [NUM_BUFS];
   logic bank_we;
   logic [IDX_W-1:0] bank_waddr;
   logic [PIXEL_WIDTH-1:0] bank_wdata;
   logic addr_ok, rd_ok, rd_zero;
   logic [BW-1:0] rd_sel;

`ifdef FB_CLEAR_ON_SWAP_EN
   logic [IDX_W-1:0] clr_addr;
`endif

   assign addr_ok = ({1'b0, addra} < DEPTH_LIM);
   assign rd_ok   = ({1'b0, addrb} < DEPTH_LIM);
   assign vs_fall = vs_prev & ~vs_s2;

   // vsync comes from the VGA clock domain; two flops, then an edge detector
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_s1   <= 1'b0;
         vs_s2   <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         vs_s1   <= vsync;
         vs_s2   <= vs_s1;
         vs_prev <= vs_s2;
      end
   end

   // Swap is resolved first so a simultaneous frame_done sees the freed display buffer
   always_comb begin
      n_state  = buf_state;
      n_disp   = disp_idx;
      n_wr     = wr_idx;
      n_pend   = pend_idx;
      n_pv     = pend_valid;
      n_wst    = wr_state;
      do_swap  = 1'b0;
      do_drop  = 1'b0;
      need_buf = 1'b0;
      found    = 1'b0;
      free_idx = '0;
      if (vs_fall && pend_valid) begin
         n_state[disp_idx] = BUF_FREE;
         n_state[pend_idx] = BUF_DISPLAY;
         n_disp  = pend_idx;
         n_pv    = 1'b0;
         do_swap = 1'b1;
      end
      if (frame_done && wr_ready) begin
         if (pend_valid && !do_swap) begin
            n_state[pend_idx] = BUF_FREE;
            do_drop = 1'b1;
         end
         n_state[wr_idx] = BUF_PENDING;
         n_pend   = wr_idx;
         n_pv     = 1'b1;
         need_buf = 1'b1;
      end
      if (wr_state == WR_STALL)
         need_buf = 1'b1;
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         if (n_state[i] == BUF_FREE) begin
            found    = 1'b1;
            free_idx = BW'(i);
         end
      end
      if (need_buf) begin
         if (found) begin
            n_wr = free_idx;
            n_state[free_idx] = BUF_WRITE;
            n_wst = WR_ENTRY;
         end else begin
            n_wst = WR_STALL;
         end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      if (wr_state == WR_CLEAR && clr_addr == IDX_W'(DEPTH - 1))
         n_wst = WR_ACTIVE;
`endif
   end

   // wr_ready drops with the state change but rises one cycle after re-entering WR_ACTIVE
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            if (i == 0)
               buf_state[i] <= BUF_DISPLAY;
            else if (i == 1)
               buf_state[i] <= BUF_WRITE;
            else
               buf_state[i] <= BUF_FREE;
         end
         wr_state   <= WR_ENTRY;
         wr_ready   <= (WR_ENTRY == WR_ACTIVE);
         disp_idx   <= BW'(0);
         wr_idx     <= BW'(1);
         pend_idx   <= '0;
         pend_valid <= 1'b0;
         swap_pulse <= 1'b0;
         frame_drop <= 1'b0;
      end else begin
         buf_state  <= n_state;
         wr_state   <= n_wst;
         wr_ready   <= (wr_state == WR_ACTIVE) && (n_wst == WR_ACTIVE);
         disp_idx   <= n_disp;
         wr_idx     <= n_wr;
         pend_idx   <= n_pend;
         pend_valid <= n_pv;
         swap_pulse <= do_swap;
         frame_drop <= do_drop;
      end
   end

`ifdef FB_CLEAR_ON_SWAP_EN
   always_ff @(posedge clk) begin
      if (rst || wr_state != WR_CLEAR)
         clr_addr <= '0;
      else
         clr_addr <= clr_addr + IDX_W'(1);
   end
`endif

   always_comb begin
      bank_we    = wea && wr_ready && addr_ok;
      bank_waddr = addra[IDX_W-1:0];
      bank_wdata = dina;
`ifdef FB_CLEAR_ON_SWAP_EN
      if (wr_state == WR_CLEAR) begin
         bank_we    = 1'b1;
         bank_waddr = clr_addr;
         bank_wdata = clear_color;
      end
`endif
   end

   for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
      fb_bank #(
         .DEPTH       (DEPTH),
         .PIXEL_WIDTH (PIXEL_WIDTH)
      ) u_bank (
         .clk     (clk),
         .we      (bank_we && (wr_idx == BW'(g))),
         .wr_addr (bank_waddr),
         .wr_data (bank_wdata),
         .rd_addr (addrb[IDX_W-1:0]),
         .rd_data (bank_q[g])
      );
   end

   // Bank select travels with the read so a swap never switches mid-read
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sel  <= '0;
         rd_zero <= 1'b1;
      end else begin
         rd_sel  <= disp_idx;
         rd_zero <= !rd_ok;
      end
   end

   assign doutb = rd_zero ? '0 : bank_q[rd_sel];

endmodule

// File: tb/tb_multi_framebuffer.sv
// Directed bench: a triple-buffer and a double-buffer instance checked against
// hand-computed buffer indices, pulses and pixel read-back.
`timescale 1ns/1ps
module tb_multi_framebuffer;

   localparam int AW = 7;
   localparam int DP = 64;

`ifdef FB_CLEAR_ON_SWAP_EN
   localparam logic EXP_RST_READY = 1'b0;
`else
   localparam logic EXP_RST_READY = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          vsync_3 = 1'b1, wea_3 = 1'b0, frame_done_3 = 1'b0;
   logic [AW-1:0] addra_3 = '0, addrb_3 = '0;
   logic [7:0]    dina_3 = '0, doutb_3;
   logic          wr_ready_3, swap_pulse_3, frame_drop_3;
   logic [1:0]    disp_idx_3, wr_idx_3;

   logic          vsync_2 = 1'b1, wea_2 = 1'b0, frame_done_2 = 1'b0;
   logic [AW-1:0] addra_2 = '0, addrb_2 = '0;
   logic [7:0]    dina_2 = '0, doutb_2;
   logic          wr_ready_2, swap_pulse_2, frame_drop_2;
   logic [0:0]    disp_idx_2, wr_idx_2;

`ifdef FB_CLEAR_ON_SWAP_EN
   logic [7:0] clear_color = 8'h3C;
`endif

   multi_framebuffer #(.ADDR_WIDTH(AW), .DEPTH(DP), .PIXEL_WIDTH(8), .NUM_BUFS(3)) dut3 (
      .clk(clk), .rst(rst), .vsync(vsync_3),
`ifdef FB_CLEAR_ON_SWAP_EN
      .clear_color(clear_color),
`endif
      .wea(wea_3), .addra(addra_3), .dina(dina_3), .frame_done(frame_done_3),
      .wr_ready(wr_ready_3), .addrb(addrb_3), .doutb(doutb_3),
      .disp_idx(disp_idx_3), .wr_idx(wr_idx_3),
      .swap_pulse(swap_pulse_3), .frame_drop(frame_drop_3)
   );

   multi_framebuffer #(.ADDR_WIDTH(AW), .DEPTH(DP), .PIXEL_WIDTH(8), .NUM_BUFS(2)) dut2 (
      .clk(clk), .rst(rst), .vsync(vsync_2),
`ifdef FB_CLEAR_ON_SWAP_EN
      .clear_color(clear_color),
`endif
      .wea(wea_2), .addra(addra_2), .dina(dina_2), .frame_done(frame_done_2),
      .wr_ready(wr_ready_2), .addrb(addrb_2), .doutb(doutb_2),
      .disp_idx(disp_idx_2), .wr_idx(wr_idx_2),
      .swap_pulse(swap_pulse_2), .frame_drop(frame_drop_2)
   );

   int total = 0;
   int bad = 0;
   int swap_cnt_3 = 0;
   int drop_cnt_3 = 0;

   always @(negedge clk) begin
      if (swap_pulse_3) swap_cnt_3++;
      if (frame_drop_3) drop_cnt_3++;
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      logic [7:0]    exp;
   } vec_t;
   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_vsync(input int which, input logic v);
      if (which == 3) vsync_3 = v; else vsync_2 = v;
   endtask

   task automatic set_done(input int which, input logic v);
      if (which == 3) frame_done_3 = v; else frame_done_2 = v;
   endtask

   task automatic write_px(input int which, input logic [AW-1:0] a, input logic [7:0] d);
      if (which == 3) begin
         wea_3 = 1'b1; addra_3 = a; dina_3 = d;
      end else begin
         wea_2 = 1'b1; addra_2 = a; dina_2 = d;
      end
      tick();
      wea_3 = 1'b0;
      wea_2 = 1'b0;
   endtask

   task automatic pulse_done(input int which);
      set_done(which, 1'b1);
      tick();
      set_done(which, 1'b0);
   endtask

   // Ends one cycle after the swap edge, with vs_fall seen on the edge before it
   task automatic vs_fall_seq(input int which, input logic with_done);
      set_vsync(which, 1'b1);
      repeat (3) tick();
      set_vsync(which, 1'b0);
      tick();
      tick();
      set_done(which, with_done);
      tick();
      set_done(which, 1'b0);
      set_vsync(which, 1'b1);
   endtask

   task automatic read_px(input int which, input logic [AW-1:0] a);
      if (which == 3) addrb_3 = a; else addrb_2 = a;
      tick();
   endtask

   int base_swap;
   int waited;
   logic [1:0] exp_disp [3];
   logic [1:0] exp_wr   [3];

   initial begin
      vecs[0] = '{addr: 7'd5,   data: 8'hAA, exp: 8'hAA};
      vecs[1] = '{addr: 7'd0,   data: 8'h11, exp: 8'h11};
      vecs[2] = '{addr: 7'd63,  data: 8'h7E, exp: 8'h7E};
      vecs[3] = '{addr: 7'd20,  data: 8'hC3, exp: 8'hC3};
      vecs[4] = '{addr: 7'd36,  data: 8'h24, exp: 8'h24};
      vecs[5] = '{addr: 7'd100, data: 8'h99, exp: 8'h00};
      exp_disp = '{2'd1, 2'd0, 2'd2};
      exp_wr   = '{2'd0, 2'd2, 2'd1};

      rst = 1'b1;
      repeat (3) tick();
      check("rst3 doutb", doutb_3, 8'h00);
      check("rst3 disp_idx", disp_idx_3, 0);
      check("rst3 wr_idx", wr_idx_3, 1);
      check("rst3 wr_ready", wr_ready_3, EXP_RST_READY);
      check("rst3 swap_pulse", swap_pulse_3, 0);
      check("rst3 frame_drop", frame_drop_3, 0);
      check("rst2 disp_idx", disp_idx_2, 0);
      check("rst2 wr_idx", wr_idx_2, 1);
      rst = 1'b0;
      tick();
      check("post-rst3 wr_idx", wr_idx_3, 1);
      check("post-rst2 wr_ready", wr_ready_2, EXP_RST_READY);

`ifdef FB_CLEAR_ON_SWAP_EN
      waited = 0;
      while (!wr_ready_3 && waited < 4 * DP) begin tick(); waited++; end
      check("reset clear finishes", wr_ready_3, 1);
      pulse_done(3);
      check("clear wr_ready low", wr_ready_3, 0);
      check("clear new wr_idx", wr_idx_3, 2);
      waited = 0;
      while (!wr_ready_3 && waited < 4 * DP) begin tick(); waited++; end
      check("clear wr_ready restored", wr_ready_3, 1);
      check("clear duration >= DEPTH", (waited + 1 >= DP) ? 1 : 0, 1);
      check("clear duration <= DEPTH+1", (waited <= DP + 1) ? 1 : 0, 1);
      pulse_done(3);
      vs_fall_seq(3, 1'b0);
      check("clear swap disp_idx", disp_idx_3, 2);
      read_px(3, 7'd0);
      check("clear color addr 0", doutb_3, 8'h3C);
      read_px(3, 7'(DP - 1));
      check("clear color addr DEPTH-1", doutb_3, 8'h3C);
`else
      // Single frame into buffer 1 then shown
      for (int i = 0; i < 6; i++)
         write_px(3, vecs[i].addr, vecs[i].data);
      pulse_done(3);
      check("t1 wr_idx after done", wr_idx_3, 2);
      check("t1 wr_ready after done", wr_ready_3, 1);
      check("t1 no drop", frame_drop_3, 0);
      vs_fall_seq(3, 1'b0);
      check("t1 swap_pulse", swap_pulse_3, 1);
      check("t1 disp_idx", disp_idx_3, 1);
      tick();
      check("t1 swap_pulse one cycle", swap_pulse_3, 0);
      for (int i = 0; i < 6; i++) begin
         read_px(3, vecs[i].addr);
         check($sformatf("t1 read addr %0d", vecs[i].addr), doutb_3, vecs[i].exp);
      end
      read_px(3, 7'd5);
      addrb_3 = 7'd20;
      #2;
      check("t1 read latency hold", doutb_3, 8'hAA);
      tick();
      check("t1 read latency new", doutb_3, 8'hC3);

      // Two completed frames with no vsync: first one is dropped
      write_px(3, 7'd5, 8'h55);
      pulse_done(3);
      check("t3 first done no drop", frame_drop_3, 0);
      check("t3 wr_idx after first", wr_idx_3, 0);
      write_px(3, 7'd5, 8'h66);
      pulse_done(3);
      check("t3 second done drops", frame_drop_3, 1);
      check("t3 wr_idx after drop", wr_idx_3, 2);
      tick();
      check("t3 drop count", drop_cnt_3, 1);

      // vs_fall and frame_done together; read in flight keeps old buffer
      addrb_3 = 7'd5;
      vs_fall_seq(3, 1'b1);
      check("t4 swap_pulse", swap_pulse_3, 1);
      check("t4 no drop", frame_drop_3, 0);
      check("t4 disp_idx", disp_idx_3, 0);
      check("t4 old display becomes wr", wr_idx_3, 1);
      check("t4 read before swap old data", doutb_3, 8'hAA);
      tick();
      check("t4 read after swap new data", doutb_3, 8'h66);
      vs_fall_seq(3, 1'b0);
      check("t4 finished buffer shown", disp_idx_3, 2);
      tick();
      check("t4 pixel of shown buffer", doutb_3, 8'h55);
      check("t4 wr_idx kept", wr_idx_3, 1);

      // vs_fall with nothing pending
      base_swap = swap_cnt_3;
      vs_fall_seq(3, 1'b0);
      check("t5 no pending no swap", swap_pulse_3, 0);
      check("t5 no pending disp", disp_idx_3, 2);

      // Long, asynchronously placed vsync low periods
      for (int k = 0; k < 3; k++) begin
         pulse_done(3);
         check($sformatf("t5 iter%0d wr_idx", k), wr_idx_3, exp_wr[k]);
         base_swap = swap_cnt_3;
         #($urandom_range(1, 8));
         vsync_3 = 1'b0;
         repeat ((k == 0) ? 1000 : 40) @(posedge clk);
         #($urandom_range(2, 7));
         vsync_3 = 1'b1;
         repeat (5) tick();
         check($sformatf("t5 iter%0d one swap", k), swap_cnt_3 - base_swap, 1);
         check($sformatf("t5 iter%0d disp_idx", k), disp_idx_3, exp_disp[k]);
      end
      check("total drops dut3", drop_cnt_3, 1);

      // Double buffer: frame_done stalls until the next vs_fall
      write_px(2, 7'd3, 8'h5A);
      pulse_done(2);
      check("t2 wr_ready low", wr_ready_2, 0);
      check("t2 no drop", frame_drop_2, 0);
      write_px(2, 7'd3, 8'hFF);
      pulse_done(2);
      check("t2 done while stalled ignored", frame_drop_2, 0);
      vs_fall_seq(2, 1'b0);
      check("t2 swap_pulse", swap_pulse_2, 1);
      check("t2 disp_idx", disp_idx_2, 1);
      check("t2 wr_idx", wr_idx_2, 0);
      check("t2 wr_ready still low", wr_ready_2, 0);
      tick();
      check("t2 wr_ready rises", wr_ready_2, 1);
      read_px(2, 7'd3);
      check("t2 stalled write ignored", doutb_2, 8'h5A);
      vs_fall_seq(2, 1'b0);
      check("t2 no pending no swap", swap_pulse_2, 0);
      check("t2 disp kept", disp_idx_2, 1);
      write_px(2, 7'd3, 8'hA5);
      pulse_done(2);
      check("t2 stalls again", wr_ready_2, 0);
      vs_fall_seq(2, 1'b0);
      check("t2 second swap disp", disp_idx_2, 0);
      check("t2 second swap wr", wr_idx_2, 1);
      read_px(2, 7'd3);
      check("t2 second frame pixel", doutb_2, 8'hA5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
